// File: rtl/sync_pkg.sv
// Shared helpers for the sync library: counter sizing and parameter sanity checks.
package sync_pkg;

    // Width needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal parameter range for the elastic pipeline: at least one bit, at least one stage.
    function automatic bit params_ok(input int size, input int depth);
        return (size >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/register_stage.sv
// One elastic pipeline stage: a valid bit plus data word that loads from the
// previous stage whenever this stage is empty or the next stage is taking its word.
module register_stage #(
    parameter int size = 1
) (
    input  logic            ctrl_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            prev_valid_i,
    input  logic [size-1:0] prev_data_i,
    input  logic            next_ready_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [size-1:0] data_o
);

    logic            valid_q, valid_d;
    logic [size-1:0] data_q,  data_d;

    // A stage can take a new word when it is empty or its current word is leaving.
    assign ready_o = ~valid_q | next_ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next-state: flush drops the valid bit only; data loads only when a real word arrives.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = prev_valid_i;
            if (prev_valid_i) begin
                data_d = prev_data_i;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge ctrl_i) begin
        // NOTE: the data word is reset too so out_data reads 0 after reset, not leftover contents.
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/register_pipeline.sv
// Elastic register pipeline: depth stages of size bits under valid/ready.
// Bubbles collapse because each stage's ready looks only at its own valid bit
// and the ready of the stage after it.
// Optional feature: define REGISTER_PIPELINE_OCCUPANCY_EN to add the occupancy port.
module register_pipeline
    import sync_pkg::*;
#(
    parameter int size  = 1,
    parameter int depth = 2
) (
    input  logic            ctrl,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_data
`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    ,
    output logic [occ_width(depth)-1:0] occupancy
`endif
);

    if (!params_ok(size, depth)) begin : g_param_check
        $error("register_pipeline: size and depth must both be at least 1");
    end

    // Index 0 is the upstream input; index i+1 is the output of stage i.
    logic [depth:0]  chain_valid;
    logic [size-1:0] chain_data [depth+1];

    assign chain_valid[0] = in_valid;
    assign chain_data[0]  = in_data;

    for (genvar i = 0; i < depth; i++) begin : g_stage
        logic stage_ready;
        logic next_ready;

        // The ready chain runs from the output back towards the input, one OR per stage.
        if (i == depth - 1) begin : g_last
            assign next_ready = out_ready;
        end else begin : g_inner
            assign next_ready = g_stage[i+1].stage_ready;
        end

        register_stage #(
            .size(size)
        ) u_stage (
            .ctrl_i      (ctrl),
            .rst_i       (rst),
            .flush_i     (flush),
            .prev_valid_i(chain_valid[i]),
            .prev_data_i (chain_data[i]),
            .next_ready_i(next_ready),
            .ready_o     (stage_ready),
            .valid_o     (chain_valid[i+1]),
            .data_o      (chain_data[i+1])
        );
    end

    assign in_ready  = g_stage[0].stage_ready & ~flush;
    assign out_valid = chain_valid[depth];
    assign out_data  = chain_data[depth];

`ifdef REGISTER_PIPELINE_OCCUPANCY_EN
    localparam int OccW = occ_width(depth);

    logic [OccW-1:0] occ_q, occ_d;
    logic            in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Count follows the handshakes; flush empties the pipe regardless of a same-cycle output.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            unique case ({in_xfer, out_xfer})
                2'b10:   occ_d = occ_q + OccW'(1);
                2'b01:   occ_d = occ_q - OccW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy register, cleared by reset.
    always_ff @(posedge ctrl) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
